dm_access: RTL and testbench

Memory-stage data access unit, the consumer of the EX/MEM register's MemOp, AO and RD2 fields. It decodes the 4-bit memory operation, checks alignment and address range, and runs a request/acknowledge transaction on the data bus with byte enables. It stalls the pipeline until the bus responds, then returns sign- or zero-extended load data, or reports an address or bus exception to the CP0 path.

---
 rtl/dm_access.sv | 96 +++++++++
 tb/tb_dm_access.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dm_access.sv
// dm_access: MEM-stage data access unit with alignment/range checks, bus handshake with timeout, and load extension.
module dm_access #(
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'h0000_2fff,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  MemOp,
  input  logic [31:0] AO,
  input  logic [31:0] RD2,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [4:0]  exc,
  output logic        exc_valid
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] op;
  logic [31:0] ao, rd2, rbuf;
  logic [7:0] cnt;
  logic [4:0] exc_r;
  logic accept, m_w, m_h, chk_ok, tmo, ld, st, is_b, is_h, is_w;
  logic [7:0] b;
  logic [15:0] h;
  assign m_w = MemOp == 4'd5 || MemOp == 4'd8;
  assign m_h = MemOp == 4'd3 || MemOp == 4'd4 || MemOp == 4'd7;
  // accept is gated by reset so stall is 0 while reset is held, even with req_valid high
  assign accept = reset && state == IDLE && req_valid && MemOp != 4'd0 && MemOp <= 4'd8;
  // offset form keeps the range check a single unsigned compare for any ADDR_LO
  assign chk_ok = !(m_w && AO[1:0] != 2'b00) && !(m_h && AO[0]) && (AO - ADDR_LO) <= (ADDR_HI - ADDR_LO);
  assign tmo = !bus_ack && cnt == 8'(TIMEOUT - 1);
  assign ld = op != 4'd0 && op <= 4'd5;
  assign st = op >= 4'd6 && op <= 4'd8;
  assign is_b = op == 4'd1 || op == 4'd2 || op == 4'd6;
  assign is_h = op == 4'd3 || op == 4'd4 || op == 4'd7;
  assign is_w = op == 4'd5 || op == 4'd8;
  assign b = rbuf[{ao[1:0], 3'b000} +: 8];
  assign h = rbuf[{ao[1], 4'b0000} +: 16];
  always_comb begin
    state_nx = state == IDLE ? (accept ? (chk_ok ? REQ : DONE) : IDLE)
             : state == REQ ? ((bus_ack || tmo) ? DONE : REQ)
             : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op <= '0;
      ao <= '0;
      rd2 <= '0;
      rbuf <= '0;
      cnt <= '0;
      exc_r <= '0;
    end else begin
      if (accept) begin
        op <= MemOp;
        ao <= AO;
        rd2 <= RD2;
        cnt <= '0;
        exc_r <= chk_ok ? 5'd0 : MemOp <= 4'd5 ? 5'd4 : 5'd5;
      end
      if (state == REQ) begin
        if (bus_ack) rbuf <= bus_rdata;
        else begin
          cnt <= cnt + 8'd1;
          if (tmo) exc_r <= 5'd7;
        end
      end
    end
  assign bus_req = state == REQ;
  assign stall = accept || bus_req;
  assign bus_we = st;
  assign bus_addr = {ao[31:2], 2'b00};
  assign bus_be = is_b ? 4'b0001 << ao[1:0] : is_h ? (ao[1] ? 4'b1100 : 4'b0011) : is_w ? 4'b1111 : 4'b0000;
  assign bus_wdata = !st ? 32'd0 : is_b ? {4{rd2[7:0]}} : is_h ? {2{rd2[15:0]}} : rd2;
  assign rdata = op == 4'd1 ? {{24{b[7]}}, b}
               : op == 4'd2 ? {24'd0, b}
               : op == 4'd3 ? {{16{h[15]}}, h}
               : op == 4'd4 ? {16'd0, h}
               : op == 4'd5 ? rbuf
               : 32'd0;
  assign exc_valid = state == DONE && exc_r != 5'd0;
  assign rdata_valid = state == DONE && exc_r == 5'd0 && ld;
  assign exc = exc_valid ? exc_r : 5'd0;
endmodule

// File: tb/tb_dm_access.sv
// tb_dm_access: directed checks of dm_access transactions, exceptions, timeout and async reset.
module tb_dm_access;
  logic clk = 0, reset = 0, req_valid = 0, bus_ack = 0;
  logic [3:0] MemOp = 0;
  logic [31:0] AO = 0, RD2 = 0, bus_rdata = 0;
  logic stall, bus_req, bus_we, rdata_valid, exc_valid;
  logic [31:0] bus_addr, bus_wdata, rdata;
  logic [3:0] bus_be;
  logic [4:0] exc;
  int checks = 0, errors = 0;
  int s_n, r_n, rv_n, ev_n;
  logic [31:0] be_o, addr_o, wd_o, we_o, rd_o, exc_o;

  dm_access dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .MemOp(MemOp), .AO(AO), .RD2(RD2),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .exc(exc), .exc_valid(exc_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 2 time units after a rising edge with the DUT idle; returns after DONE, positioned likewise.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                     input int ack_n, input logic [31:0] rd);
    logic fin;
    int i;
    fin = 0;
    i = 0;
    s_n = 0; r_n = 0; rv_n = 0; ev_n = 0;
    be_o = 0; addr_o = 0; wd_o = 0; we_o = 0; rd_o = 0; exc_o = 0;
    req_valid = 1; MemOp = op; AO = a; RD2 = d;
    while (!fin && i < 40) begin
      #1;
      if (stall) s_n++;
      if (bus_req) begin
        r_n++;
        be_o = {28'd0, bus_be}; addr_o = bus_addr; wd_o = bus_wdata; we_o = {31'd0, bus_we};
        if (r_n == ack_n) begin bus_ack = 1; bus_rdata = rd; end
      end
      if (rdata_valid) begin rv_n++; rd_o = rdata; end
      if (exc_valid) begin ev_n++; exc_o = {27'd0, exc}; end
      if (!stall && s_n > 0) fin = 1;
      else begin
        @(posedge clk); #2;
        bus_ack = 0;
        i++;
      end
    end
    req_valid = 0; MemOp = 0;
    chk("done_reached", {31'd0, fin}, 32'd1);
    @(posedge clk); #2;
    bus_ack = 0;
  endtask

  initial begin
    req_valid = 1; MemOp = 4'd5; AO = 32'h10;
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulses", {30'd0, rdata_valid, exc_valid}, 32'd0);
    chk("rst_exc", {27'd0, exc}, 32'd0);
    @(posedge clk); #2;
    req_valid = 0; MemOp = 0; AO = 0;
    reset = 1;
    @(posedge clk); #2;

    // sw, ack in 3rd REQ cycle
    run(4'd8, 32'h10, 32'h12345678, 3, 32'h0);
    chk("sw_be", be_o, 32'hf);
    chk("sw_wdata", wd_o, 32'h12345678);
    chk("sw_we", we_o, 32'd1);
    chk("sw_addr", addr_o, 32'h10);
    chk("sw_stall", s_n, 4);
    chk("sw_req", r_n, 3);
    chk("sw_pulses", rv_n + ev_n, 0);

    run(4'd6, 32'h13, 32'h000000AB, 1, 32'h0);
    chk("sb_addr", addr_o, 32'h10);
    chk("sb_be", be_o, 32'h8);
    chk("sb_wdata", wd_o, 32'hABABABAB);
    chk("sb_stall", s_n, 2);

    run(4'd1, 32'h22, 32'h0, 1, 32'h00800000);
    chk("lb_rdata", rd_o, 32'hFFFFFF80);
    chk("lb_be", be_o, 32'h4);
    chk("lb_addr", addr_o, 32'h20);
    chk("lb_we", we_o, 32'd0);
    chk("lb_rv", rv_n, 1);
    chk("lb_stall", s_n, 2);

    run(4'd2, 32'h22, 32'h0, 1, 32'h00800000);
    chk("lbu_rdata", rd_o, 32'h00000080);

    run(4'd3, 32'h2, 32'h0, 2, 32'h80010000);
    chk("lh_be", be_o, 32'hC);
    chk("lh_rdata", rd_o, 32'hFFFF8001);
    chk("lh_stall", s_n, 3);

    run(4'd4, 32'h20, 32'h0, 1, 32'h12348001);
    chk("lhu_be", be_o, 32'h3);
    chk("lhu_rdata", rd_o, 32'h00008001);

    run(4'd5, 32'h6, 32'h0, 1, 32'h0);
    chk("lw_mis_exc", exc_o, 32'd4);
    chk("lw_mis_ev", ev_n, 1);
    chk("lw_mis_stall", s_n, 1);
    chk("lw_mis_req", r_n, 0);
    chk("lw_mis_rv", rv_n, 0);

    run(4'd7, 32'h5, 32'h0, 1, 32'h0);
    chk("sh_mis_exc", exc_o, 32'd5);
    chk("sh_mis_req", r_n, 0);

    run(4'd5, 32'h3000, 32'h0, 1, 32'h0);
    chk("lw_range_exc", exc_o, 32'd4);
    chk("lw_range_req", r_n, 0);

    run(4'd5, 32'h2ffc, 32'h0, 1, 32'h5A5A0001);
    chk("lw_top_rdata", rd_o, 32'h5A5A0001);
    chk("lw_top_ev", ev_n, 0);

    run(4'd5, 32'h100, 32'h0, 0, 32'h0);
    chk("tmo_req", r_n, 15);
    chk("tmo_stall", s_n, 16);
    chk("tmo_exc", exc_o, 32'd7);
    chk("tmo_rv", rv_n, 0);

    // unsupported MemOp is not accepted
    req_valid = 1; MemOp = 4'd9; AO = 32'h10;
    #1;
    chk("op9_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #2;
    chk("op9_req", {31'd0, bus_req}, 32'd0);
    req_valid = 0; MemOp = 0;

    // reset asserted in the 2nd REQ cycle
    req_valid = 1; MemOp = 4'd5; AO = 32'h0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("mid_req_before", {31'd0, bus_req}, 32'd1);
    reset = 0;
    #1;
    chk("mid_req_after", {31'd0, bus_req}, 32'd0);
    chk("mid_stall_after", {31'd0, stall}, 32'd0);
    @(posedge clk); #2;
    reset = 1; req_valid = 0; MemOp = 0;
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    #1;
    chk("late_ack_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #2;
    bus_ack = 0;
    chk("late_ack_pulses", {30'd0, rdata_valid, exc_valid}, 32'd0);
    chk("late_ack_stall", {31'd0, stall}, 32'd0);

    run(4'd5, 32'h0, 32'h0, 2, 32'hCAFEBABE);
    chk("post_rst_rdata", rd_o, 32'hCAFEBABE);
    chk("post_rst_stall", s_n, 3);
    chk("post_rst_rv", rv_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
